// File: rtl/pe_pkg.sv
// Shared constants, FSM state type and helpers for the PE operand feeder.
package pe_pkg;

    localparam int DATA_W        = 16;
    localparam int DEPTH         = 16;
    localparam int ADDR_W        = $clog2(DEPTH);
    localparam int CNT_W         = 8;
    localparam int DRAIN_TIMEOUT = 255;

    typedef enum logic [2:0] {
        IDLE,
        START,
        FEED,
        DRAIN,
        DONE
    } state_t;

    // A job can never stream more pairs than the buffer holds.
    function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] len);
        return (len > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : len;
    endfunction

endpackage

// File: rtl/pe_feed_buf.sv
// 16 x 32-bit operand store: one synchronous write port, one combinational
// read port. Contents are deliberately not reset.
module pe_feed_buf
    import pe_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_a,
    input  logic [DATA_W-1:0] wr_b,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b
);

    logic [2*DATA_W-1:0] mem [DEPTH];

    // Store the A/B pair as one word so both halves always move together.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= {wr_a, wr_b};
        end
    end

    assign {rd_a, rd_b} = mem[rd_addr];

endmodule

// File: rtl/pe_feeder.sv
// Streams buffered A/B operand pairs into a PE, waits for its result with a
// drain timeout, and reports the outcome with a one-cycle done pulse.
module pe_feeder
    import pe_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic signed [DATA_W-1:0] wr_a,
    input  logic signed [DATA_W-1:0] wr_b,
    input  logic [CNT_W-1:0]         cfg_len,
    input  logic                     go,
    output logic                     busy,
    output logic                     done,
    output logic signed [DATA_W-1:0] result,
    output logic                     result_sat,
    output logic                     result_err,
    output logic                     pe_start,
    output logic                     pe_awe,
    output logic                     pe_bwe,
    output logic signed [DATA_W-1:0] pe_a,
    output logic signed [DATA_W-1:0] pe_b,
    output logic [CNT_W-1:0]         pe_max_cntr,
    input  logic                     pe_aff,
    input  logic                     pe_bff,
    input  logic                     pe_fout,
    input  logic signed [DATA_W-1:0] pe_s,
    input  logic                     pe_sat
);

    state_t                     state_reg, state_next;
    logic [CNT_W-1:0]           len_reg, len_next;
    logic [ADDR_W:0]            k_reg, k_next;       // one extra bit so k can reach DEPTH
    logic [CNT_W-1:0]           tmo_reg, tmo_next;
    logic signed [DATA_W-1:0]   result_reg, result_next;
    logic                       sat_reg, sat_next;
    logic                       err_reg, err_next;
    logic                       feed_wr;
    logic [DATA_W-1:0]          buf_a, buf_b;

    // The buffer is frozen for the whole job; only IDLE accepts host writes.
    pe_feed_buf u_buf (
        .clk     (clk),
        .wr_en   (wr_en && (state_reg == IDLE)),
        .wr_addr (wr_addr),
        .wr_a    (wr_a),
        .wr_b    (wr_b),
        .rd_addr (k_reg[ADDR_W-1:0]),
        .rd_a    (buf_a),
        .rd_b    (buf_b)
    );

    // Next-state, datapath updates and PE/handshake outputs.
    always_comb begin
        state_next  = state_reg;
        len_next    = len_reg;
        k_next      = k_reg;
        tmo_next    = tmo_reg;
        result_next = result_reg;
        sat_next    = sat_reg;
        err_next    = err_reg;
        pe_start    = 1'b0;
        feed_wr     = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (go) begin
                    k_next = '0;
                    if (cfg_len == '0) begin
                        // Empty job: skip the PE entirely and report a zero result.
                        len_next    = '0;
                        result_next = '0;
                        sat_next    = 1'b0;
                        err_next    = 1'b0;
                        state_next  = DONE;
                    end else begin
                        len_next   = clamp_len(cfg_len);
                        state_next = START;
                    end
                end
            end
            START: begin
                busy       = 1'b1;
                pe_start   = 1'b1;
                k_next     = '0;
                state_next = FEED;
            end
            FEED: begin
                busy     = 1'b1;
                tmo_next = '0;
                // Either FIFO full stalls both, keeping A and B in lockstep.
                if (!pe_aff && !pe_bff) begin
                    feed_wr = 1'b1;
                    k_next  = k_reg + 1'b1;
                    if (CNT_W'(k_next) == len_reg) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                busy     = 1'b1;
                tmo_next = tmo_reg + 1'b1;
                if (pe_fout) begin
                    result_next = pe_s;
                    sat_next    = pe_sat;
                    err_next    = 1'b0;
                    state_next  = DONE;
                end else if (tmo_reg == CNT_W'(DRAIN_TIMEOUT - 1)) begin
                    // PE never answered: flag it, keep the previous result.
                    err_next   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                tmo_next   = '0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Job length, feed index, drain timer and captured result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_reg    <= '0;
            k_reg      <= '0;
            tmo_reg    <= '0;
            result_reg <= '0;
            sat_reg    <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            len_reg    <= len_next;
            k_reg      <= k_next;
            tmo_reg    <= tmo_next;
            result_reg <= result_next;
            sat_reg    <= sat_next;
            err_reg    <= err_next;
        end
    end

    assign pe_awe      = feed_wr;
    assign pe_bwe      = feed_wr;
    assign pe_a        = feed_wr ? buf_a : '0;
    assign pe_b        = feed_wr ? buf_b : '0;
    assign pe_max_cntr = len_reg;
    assign result      = result_reg;
    assign result_sat  = sat_reg;
    assign result_err  = err_reg;

endmodule

// File: tb/tb_pe_feeder.sv
// Self-checking bench for pe_feeder: directed jobs plus randomized jobs,
// each checked against an expected outcome derived from the job parameters.
module tb_pe_feeder;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               wr_en = 1'b0;
    logic [3:0]         wr_addr = '0;
    logic signed [15:0] wr_a = '0;
    logic signed [15:0] wr_b = '0;
    logic [7:0]         cfg_len = '0;
    logic               go = 1'b0;
    logic               busy, done, result_sat, result_err;
    logic signed [15:0] result;
    logic               pe_start, pe_awe, pe_bwe;
    logic signed [15:0] pe_a, pe_b;
    logic [7:0]         pe_max_cntr;
    logic               pe_aff = 1'b0;
    logic               pe_bff = 1'b0;
    logic               pe_fout = 1'b0;
    logic signed [15:0] pe_s = '0;
    logic               pe_sat = 1'b0;

    int errors = 0;
    int checks = 0;

    // Reference view of the operand buffer and of the last reported result.
    logic [15:0]        ref_a [16];
    logic [15:0]        ref_b [16];
    logic signed [15:0] ref_result = '0;
    logic               ref_sat = 1'b0;
    logic               ref_err = 1'b0;
    bit                 fa [1024];
    bit                 fb [1024];

    always #5 clk = ~clk;

    pe_feeder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_a        (wr_a),
        .wr_b        (wr_b),
        .cfg_len     (cfg_len),
        .go          (go),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .result_sat  (result_sat),
        .result_err  (result_err),
        .pe_start    (pe_start),
        .pe_awe      (pe_awe),
        .pe_bwe      (pe_bwe),
        .pe_a        (pe_a),
        .pe_b        (pe_b),
        .pe_max_cntr (pe_max_cntr),
        .pe_aff      (pe_aff),
        .pe_bff      (pe_bff),
        .pe_fout     (pe_fout),
        .pe_s        (pe_s),
        .pe_sat      (pe_sat)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int addr, input logic [15:0] a, input logic [15:0] b);
        wr_en   = 1'b1;
        wr_addr = 4'(addr);
        wr_a    = a;
        wr_b    = b;
        ref_a[addr] = a;
        ref_b[addr] = b;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        chk({name, ".busy"}, busy, 0);
        chk({name, ".done"}, done, 0);
        chk({name, ".pe_start"}, pe_start, 0);
        chk({name, ".pe_we"}, {pe_awe, pe_bwe}, 0);
        chk({name, ".pe_ab"}, {pe_a, pe_b}, 0);
        chk({name, ".pe_max_cntr"}, pe_max_cntr, 0);
        chk({name, ".result"}, {result_sat, result_err, result}, 0);
    endtask

    // One job: fmode 0 = no back-pressure, 1 = random full flags,
    // 2 = pe_aff high in cycles 3..5. fout_dly < 0 means the PE never answers.
    task automatic run_job(input string name, input int cfg, input int fmode,
                           input int fout_dly, input bit noise,
                           input logic [15:0] s_in, input logic sat_in,
                           input bit wr_with_go, input int wa,
                           input logic [15:0] a, input logic [15:0] b);
        int L, t, w, drain_c, fout_c, exp_done, done_c, starts, start_c;
        int stall_wr, lock_err, idle_data, busy_err, mc_err, bad;
        logic [15:0] qa [$];
        logic [15:0] qb [$];
        L = (cfg > 16) ? 16 : cfg;
        for (int i = 0; i < 1024; i++) begin
            fa[i] = 1'b0;
            fb[i] = 1'b0;
            if (fmode == 1) begin
                fa[i] = ($urandom_range(0, 3) == 0);
                fb[i] = ($urandom_range(0, 3) == 0);
            end else if (fmode == 2) begin
                fa[i] = (i >= 3 && i <= 5);
            end
        end
        // Pairs go out from cycle 2, one per cycle without a full flag.
        t = 2;
        w = 0;
        while (w < L && t < 700) begin
            if (!(fa[t] || fb[t])) w++;
            t++;
        end
        drain_c = t;
        if (L == 0) begin
            exp_done = 1;
            fout_c   = -1;
        end else if (fout_dly < 0) begin
            exp_done = drain_c + 255;
            fout_c   = -1;
        end else begin
            fout_c   = drain_c + fout_dly;
            exp_done = fout_c + 1;
        end

        // Cycle 0: request the job (optionally with a same-cycle write).
        go      = 1'b1;
        cfg_len = 8'(cfg);
        if (wr_with_go) begin
            wr_en   = 1'b1;
            wr_addr = 4'(wa);
            wr_a    = a;
            wr_b    = b;
            ref_a[wa] = a;
            ref_b[wa] = b;
        end
        @(negedge clk);
        chk({name, ".busy_at_go"}, busy, 0);
        tick();
        go    = 1'b0;
        wr_en = 1'b0;

        done_c = -1; starts = 0; start_c = -1;
        stall_wr = 0; lock_err = 0; idle_data = 0; busy_err = 0; mc_err = 0;
        for (int c = 1; c <= exp_done + 20 && done_c < 0; c++) begin
            pe_aff  = fa[c];
            pe_bff  = fb[c];
            pe_fout = (c == fout_c) || (noise && c < drain_c && $urandom_range(0, 3) == 0);
            pe_s    = (c == fout_c) ? s_in : 16'($urandom);
            pe_sat  = (c == fout_c) ? sat_in : 1'($urandom_range(0, 1));
            if (noise && c < exp_done) begin
                go      = ($urandom_range(0, 3) == 0);
                wr_en   = ($urandom_range(0, 1) == 0);
                wr_addr = 4'($urandom);
                wr_a    = 16'($urandom);
                wr_b    = 16'($urandom);
                cfg_len = 8'($urandom);
            end else begin
                go    = 1'b0;
                wr_en = 1'b0;
            end
            @(negedge clk);
            if (pe_start === 1'b1) begin
                starts++;
                start_c = c;
            end
            if (pe_awe === 1'b1 || pe_bwe === 1'b1) begin
                if (!(pe_awe === 1'b1 && pe_bwe === 1'b1)) lock_err++;
                if (fa[c] || fb[c]) stall_wr++;
                qa.push_back(pe_a);
                qb.push_back(pe_b);
            end else if (pe_a !== 16'sd0 || pe_b !== 16'sd0) begin
                idle_data++;
            end
            if (c < exp_done) begin
                if (busy !== 1'b1 || done !== 1'b0) busy_err++;
            end else if (c == exp_done) begin
                if (busy !== 1'b0) busy_err++;
            end
            if (pe_max_cntr !== 8'(L)) mc_err++;
            if (done === 1'b1) done_c = c;
            tick();
        end
        go = 1'b0; wr_en = 1'b0; pe_fout = 1'b0; pe_aff = 1'b0; pe_bff = 1'b0;

        if (L == 0) begin
            ref_result = '0; ref_sat = 1'b0; ref_err = 1'b0;
        end else if (fout_c < 0) begin
            ref_err = 1'b1;
        end else begin
            ref_result = s_in; ref_sat = sat_in; ref_err = 1'b0;
        end

        bad = 0;
        for (int i = 0; i < qa.size() && i < L; i++) begin
            if (qa[i] !== ref_a[i] || qb[i] !== ref_b[i]) bad++;
        end
        chk({name, ".done_cycle"}, done_c, exp_done);
        chk({name, ".start_count"}, starts, (L == 0) ? 0 : 1);
        if (L > 0) chk({name, ".start_cycle"}, start_c, 1);
        chk({name, ".write_count"}, qa.size(), L);
        chk({name, ".pair_order_bad"}, bad, 0);
        chk({name, ".write_while_full"}, stall_wr, 0);
        chk({name, ".lockstep_err"}, lock_err, 0);
        chk({name, ".idle_data"}, idle_data, 0);
        chk({name, ".busy_err"}, busy_err, 0);
        chk({name, ".max_cntr_err"}, mc_err, 0);
        chk({name, ".result"}, result, ref_result);
        chk({name, ".result_sat"}, result_sat, ref_sat);
        chk({name, ".result_err"}, result_err, ref_err);
        @(negedge clk);
        chk({name, ".done_after"}, {done, busy}, 0);
        tick();
        $display("job %s: len=%0d done_cycle=%0d writes=%0d result=%0d sat=%0b err=%0b",
                 name, L, done_c, qa.size(), result, result_sat, result_err);
    endtask

    initial begin
        // Reset state.
        rst_n = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Basic job: four pairs, PE answers 1234.
        write_entry(0, 16'd100, 16'd200);
        write_entry(1, 16'd300, 16'd100);
        write_entry(2, 16'd255, 16'd256);
        write_entry(3, 16'd100, 16'd100);
        run_job("basic4", 4, 0, 3, 1'b0, 16'd1234, 1'b0, 1'b0, 0, '0, '0);
        chk("basic4.max_cntr_after", pe_max_cntr, 4);

        // Same job with A FIFO full in cycles 3..5.
        run_job("aff_stall", 4, 2, 2, 1'b0, 16'd1234, 1'b0, 1'b0, 0, '0, '0);

        // Zero-length job.
        run_job("len0", 0, 0, 0, 1'b0, '0, 1'b0, 1'b0, 0, '0, '0);

        // Oversized length clamps to the full buffer.
        for (int i = 0; i < 16; i++) write_entry(i, 16'($urandom), 16'($urandom));
        run_job("len20", 20, 1, 5, 1'b1, 16'($urandom), 1'b1, 1'b0, 0, '0, '0);

        // PE never answers: drain timeout.
        run_job("timeout", 7, 1, -1, 1'b1, '0, 1'b0, 1'b0, 0, '0, '0);

        // Reset mid-FEED, then a fresh job.
        go = 1'b1;
        cfg_len = 8'd16;
        tick();
        go = 1'b0;
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        ref_result = '0; ref_sat = 1'b0; ref_err = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        run_job("after_reset", 16, 1, 4, 1'b0, 16'($urandom), 1'b0, 1'b0, 0, '0, '0);

        // Write and go in the same cycle: the new entry must be streamed.
        run_job("wr_with_go", 1, 0, 1, 1'b0, 16'hbeef, 1'b1, 1'b1, 0, 16'h1357, 16'h2468);

        // Randomized jobs with back-pressure, spurious go/wr/fout.
        for (int j = 0; j < 8; j++) begin
            for (int n = 0; n < 3; n++) write_entry($urandom_range(0, 15), 16'($urandom), 16'($urandom));
            run_job($sformatf("rand%0d", j), $urandom_range(0, 40), 1,
                    ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, 20),
                    1'b1, 16'($urandom), 1'($urandom_range(0, 1)), 1'b0, 0, '0, '0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
